// File: rtl/mp_add_seq_pkg.sv
// Shared definitions for the multi-precision adder sequencer: byte width,
// FSM state encoding and an index-width helper.
package mp_add_pkg;

  localparam int BYTE_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Byte index width; a single-byte operand still gets a 1-bit index.
  function automatic int idx_w(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/mp_add_seq_if.sv
// Request/result bundle for mp_add_seq: start handshake with operands,
// done handshake with Sum/Cout, plus the busy status.
interface mp_add_seq_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         Sub;
  logic         done_valid;
  logic         done_ready;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         busy;

  modport master (
    output start_valid, A, B, Cin, Sub, done_ready,
    input  start_ready, done_valid, Sum, Cout, busy
  );

  modport slave (
    input  start_valid, A, B, Cin, Sub, done_ready,
    output start_ready, done_valid, Sum, Cout, busy
  );

endinterface

// File: rtl/mp_add_seq_rca8bit.sv
// RCA8bit: purely combinational 8-bit ripple-carry adder, the shared
// byte datapath of the sequencer.
module RCA8bit (
  output logic [7:0] Sum,
  output logic       Cout,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin
);

  logic [8:0] c;

  always_comb begin
    c    = '0;
    Sum  = '0;
    c[0] = Cin;
    for (int unsigned i = 0; i < 8; i++) begin
      Sum[i]  = A[i] ^ B[i] ^ c[i];
      c[i+1]  = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    Cout = c[8];
  end

endmodule

// File: rtl/mp_add_seq.sv
// mp_add_seq: adds two NBYTES-wide operands one byte per clock, LSB first,
// through one RCA8bit. Define MP_ADD_SEQ_SUB_EN to honour the Sub request.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input logic          clk,
  input logic          rst,
  mp_add_seq_if.slave  bus
);

  localparam int                W    = BYTE_W * NBYTES;
  localparam int                IW   = idx_w(NBYTES);
  localparam logic [IW-1:0]     LAST = IW'(NBYTES - 1);

  state_t          state;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            sub_q;
  logic [W-1:0]    sum_q;
  logic            cout_q;

  logic [BYTE_W-1:0] a_byte;
  logic [BYTE_W-1:0] b_byte;
  logic [BYTE_W-1:0] rca_sum;
  logic              rca_cout;
  logic              sub_in;

`ifdef MP_ADD_SEQ_SUB_EN
  assign sub_in = bus.Sub;
`else
  logic unused_sub;
  assign unused_sub = bus.Sub;
  assign sub_in     = 1'b0;
`endif

  // Subtraction is A + ~B + 1: invert B bytewise, force the initial carry.
  always_comb begin
    a_byte = a_q[BYTE_W*idx +: BYTE_W];
    b_byte = b_q[BYTE_W*idx +: BYTE_W] ^ {BYTE_W{sub_q}};
  end

  RCA8bit u_rca (
    .Sum  (rca_sum),
    .Cout (rca_cout),
    .A    (a_byte),
    .B    (b_byte),
    .Cin  (carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start_valid) begin
            a_q   <= bus.A;
            b_q   <= bus.B;
            sub_q <= sub_in;
            carry <= sub_in ? 1'b1 : bus.Cin;
            idx   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_q[BYTE_W*idx +: BYTE_W] <= rca_sum;
          carry                       <= rca_cout;
          // idx stays at the last byte rather than wrapping past NBYTES-1.
          if (idx == LAST) begin
            cout_q <= rca_cout;
            state  <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.done_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.start_ready = (state == ST_IDLE) && !rst;
  assign bus.done_valid  = (state == ST_DONE);
  assign bus.busy        = (state != ST_IDLE);
  assign bus.Sum         = sum_q;
  assign bus.Cout        = cout_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed bench for mp_add_seq: NBYTES=4 and NBYTES=1 instances, checked
// against hand-computed sums, latency and handshake behaviour.
module tb_mp_add_seq;

  logic clk;
  logic rst;

  int compared;
  int mismatched;

  mp_add_seq_if #(.NBYTES(4)) bus4 ();
  mp_add_seq_if #(.NBYTES(1)) bus1 ();

  mp_add_seq #(.NBYTES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  mp_add_seq #(.NBYTES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request on the 4-byte DUT and count clocks until done_valid.
  task automatic issue4(input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, output int lat);
    @(negedge clk);
    bus4.A = a; bus4.B = b; bus4.Cin = cin; bus4.Sub = sub;
    bus4.start_valid = 1'b1;
    @(posedge clk); #1;
    bus4.start_valid = 1'b0;
    lat = 0;
    while (!bus4.done_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release4();
    @(negedge clk);
    bus4.done_ready = 1'b1;
    @(posedge clk); #1;
    bus4.done_ready = 1'b0;
  endtask

  int          lat;
  logic [31:0] held_sum;

  initial begin
    compared = 0; mismatched = 0;
    rst = 1'b1;
    bus4.start_valid = 1'b0; bus4.A = '0; bus4.B = '0; bus4.Cin = 1'b0;
    bus4.Sub = 1'b0; bus4.done_ready = 1'b0;
    bus1.start_valid = 1'b0; bus1.A = '0; bus1.B = '0; bus1.Cin = 1'b0;
    bus1.Sub = 1'b0; bus1.done_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_sum", bus4.Sum, 32'h0);
    chk("rst_cout", 32'(bus4.Cout), 32'h0);
    chk("rst_done_valid", 32'(bus4.done_valid), 32'h0);
    chk("rst_busy", 32'(bus4.busy), 32'h0);
    #10 rst = 1'b0;
    #1;
    chk("rst_start_ready", 32'(bus4.start_ready), 32'h1);

    // 1: byte-0 carry into byte 1, exact latency
    issue4(32'h0000_00FF, 32'h1, 1'b0, 1'b0, lat);
    chk("t1_latency", 32'(lat), 32'd4);
    chk("t1_sum", bus4.Sum, 32'h0000_0100);
    chk("t1_cout", 32'(bus4.Cout), 32'h0);
    chk("t1_busy", 32'(bus4.busy), 32'h1);
    release4();
    chk("t1_ready_after", 32'(bus4.start_ready), 32'h1);

    // 2: carry ripples through every byte
    issue4(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
    chk("t2_latency", 32'(lat), 32'd4);
    chk("t2_sum", bus4.Sum, 32'h0);
    chk("t2_cout", 32'(bus4.Cout), 32'h1);
    release4();

    // 3: Cin=1 on both widths
    issue4(32'h2F, 32'h81, 1'b1, 1'b0, lat);
    chk("t3_sum", bus4.Sum, 32'hB1);
    chk("t3_cout", 32'(bus4.Cout), 32'h0);

    @(negedge clk);
    bus1.A = 8'h2F; bus1.B = 8'h81; bus1.Cin = 1'b1; bus1.start_valid = 1'b1;
    @(posedge clk); #1;
    bus1.start_valid = 1'b0;
    chk("t3n1_not_done_at_accept", 32'(bus1.done_valid), 32'h0);
    @(posedge clk); #1;
    chk("t3n1_done_after_1", 32'(bus1.done_valid), 32'h1);
    chk("t3n1_sum", 32'(bus1.Sum), 32'hB1);
    chk("t3n1_cout", 32'(bus1.Cout), 32'h0);

    // 4: hold DONE with a stray start pulse; t3 result must survive
    held_sum = bus4.Sum;
    @(negedge clk);
    bus4.A = 32'hDEAD_BEEF; bus4.B = 32'h1234_5678; bus4.start_valid = 1'b1;
    @(negedge clk);
    bus4.start_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_sum_held", bus4.Sum, held_sum);
    chk("t4_cout_held", 32'(bus4.Cout), 32'h0);
    chk("t4_still_done", 32'(bus4.done_valid), 32'h1);
    chk("t4_start_ready_low", 32'(bus4.start_ready), 32'h0);
    release4();
    chk("t4_idle", 32'(bus4.busy), 32'h0);
    issue4(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, lat);
    chk("t4_new_latency", 32'(lat), 32'd4);
    chk("t4_new_sum", bus4.Sum, 32'h2345_6789);
    release4();

    // 5: async reset during the 2nd RUN cycle
    @(negedge clk);
    bus4.A = 32'h0101_0101; bus4.B = 32'h0202_0202; bus4.Cin = 1'b0;
    bus4.start_valid = 1'b1;
    @(posedge clk); #1;
    bus4.start_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t5_sum_zero", bus4.Sum, 32'h0);
    chk("t5_busy_zero", 32'(bus4.busy), 32'h0);
    chk("t5_done_zero", 32'(bus4.done_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_ready_after", 32'(bus4.start_ready), 32'h1);
    issue4(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, lat);
    chk("t5_sum", bus4.Sum, 32'h1);
    chk("t5_cout", 32'(bus4.Cout), 32'h1);
    release4();

    // 6: Sub request, behaviour depends on build
    issue4(32'h100, 32'h1, 1'b0, 1'b1, lat);
`ifdef MP_ADD_SEQ_SUB_EN
    chk("t6a_sum", bus4.Sum, 32'hFF);
    chk("t6a_cout", 32'(bus4.Cout), 32'h1);
`else
    chk("t6a_sum", bus4.Sum, 32'h101);
    chk("t6a_cout", 32'(bus4.Cout), 32'h0);
`endif
    release4();
    issue4(32'h0, 32'h1, 1'b0, 1'b1, lat);
`ifdef MP_ADD_SEQ_SUB_EN
    chk("t6b_sum", bus4.Sum, 32'hFFFF_FFFF);
    chk("t6b_cout", 32'(bus4.Cout), 32'h0);
`else
    chk("t6b_sum", bus4.Sum, 32'h1);
    chk("t6b_cout", 32'(bus4.Cout), 32'h0);
`endif
    release4();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
